mul_share_ctrl: RTL and testbench

MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

---
 rtl/mul_share_ctrl.sv | 129 ++++++++++++
 tb/tb_mul_share_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// Shared shift-add multiplier arbitrating two requesters round-robin, one job in flight.
// Latency: grant edge to out_valid edge spans WIDTH+1 rising edges; job-to-job spacing WIDTH+2 cycles.
// Backpressure: requesters hold req/a/b until their gnt pulse; requests seen outside IDLE wait.
module mul_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic                 out_id
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [2*WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]     mplier, mplier_nxt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [2*WIDTH-1:0]   sum;
    logic                 last, last_nxt;
    logic                 win;
    logic                 gnt0_nxt, gnt1_nxt, busy_nxt, out_valid_nxt, out_id_nxt;
    logic [2*WIDTH-1:0]   out_nxt;

    // Partial-product step; on the final count this is the finished product.
    assign sum = acc + (mplier[0] ? mcand : '0);

    // Ties go to whoever was not served last; a lone request always wins.
    assign win = (req0 && req1) ? ~last : req1;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mcand_nxt     = mcand;
        mplier_nxt    = mplier;
        acc_nxt       = acc;
        last_nxt      = last;
        gnt0_nxt      = 1'b0;
        gnt1_nxt      = 1'b0;
        out_valid_nxt = 1'b0;
        out_nxt       = out;
        out_id_nxt    = out_id;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    mcand_nxt  = {{WIDTH{1'b0}}, (win ? a1 : a0)};
                    mplier_nxt = win ? b1 : b0;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    gnt0_nxt   = ~win;
                    gnt1_nxt   = win;
                    out_id_nxt = win;
                    last_nxt   = win;
                    state_nxt  = S_CALC;
                end
            end
            S_CALC: begin
                acc_nxt    = sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_nxt       = '0;
                    out_nxt       = sum;
                    out_valid_nxt = 1'b1;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            acc       <= acc_nxt;
            last      <= last_nxt;
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            busy      <= busy_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            out_id    <= out_id_nxt;
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: scoreboard of expected (id, product) pairs popped on out_valid.
module tb_mul_share_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic               id;
        logic [2*WIDTH-1:0] prod;
    } exp_t;

    logic               CLK = 1'b0;
    logic               reset;
    logic               req0, req1;
    logic [WIDTH-1:0]   a0, b0, a1, b1;
    logic               gnt0, gnt1, busy, out_valid, out_id;
    logic [2*WIDTH-1:0] out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvalid = 0;
    int last_gnt_cyc = 0;
    int g_cyc = 0;
    logic prev_valid = 1'b0;
    bit ok;
    exp_t exp_q[$];
    bit   gnt_log[$];

    mul_share_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .out(out), .out_valid(out_valid), .out_id(out_id)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input bit id, input int a, input int b);
        exp_t e;
        e.id   = id;
        e.prod = (2*WIDTH)'(a * b);
        return e;
    endfunction

    // Output monitor: grant log, scoreboard pops, latency and pulse-width checks.
    always @(negedge CLK) begin
        if (gnt0 || gnt1) begin
            chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
            gnt_log.push_back(gnt1);
            last_gnt_cyc = cyc;
        end
        if (out_valid) begin
            chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
            // Grant edge and out_valid edge are WIDTH+1 edges inclusive, i.e. WIDTH cycles apart.
            chk("latency", cyc - last_gnt_cyc, WIDTH);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out", {16'd0, out}, {16'd0, e.prod});
                chk("out_id", {31'd0, out_id}, {31'd0, e.id});
            end
            nvalid++;
        end
        prev_valid = out_valid;
    end

    task automatic wait_gnt(input bit id, output bit found);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CLK);
            if (id ? gnt1 : gnt0) found = 1'b1;
        end
        if (!found) chk(id ? "timeout_gnt1" : "timeout_gnt0", 32'd0, 32'd1);
    endtask

    task automatic wait_valids(input int target);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (nvalid >= target) done = 1'b1;
        end
        if (!done) chk("timeout_valid", nvalid, target);
    endtask

    task automatic run_single(input bit id, input int a, input int b);
        int base;
        base = nvalid;
        @(negedge CLK);
        if (id) begin req1 = 1'b1; a1 = WIDTH'(a); b1 = WIDTH'(b); end
        else    begin req0 = 1'b1; a0 = WIDTH'(a); b0 = WIDTH'(b); end
        exp_q.push_back(mk(id, a, b));
        wait_gnt(id, ok);
        chk("busy_after_gnt", {31'd0, busy}, 32'd1);
        // Scramble operands after the grant; the job in flight must not see them.
        if (id) begin req1 = 1'b0; a1 = 8'hA5; b1 = 8'h5A; end
        else    begin req0 = 1'b0; a0 = 8'hC3; b0 = 8'h3C; end
        wait_valids(base + 1);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_id", {31'd0, out_id}, 32'd0);
        reset = 1'b0;

        // Tie straight after reset: requester 0 first, requester 1 on the first IDLE cycle.
        req0 = 1'b1; a0 = 8'd10;  b0 = 8'd14;
        req1 = 1'b1; a1 = 8'd123; b1 = 8'd7;
        exp_q.push_back(mk(0, 10, 14));
        exp_q.push_back(mk(1, 123, 7));
        wait_gnt(0, ok);
        chk("tie_no_gnt1", {31'd0, gnt1}, 32'd0);
        g_cyc = cyc;
        req0 = 1'b0;
        wait_gnt(1, ok);
        chk("tie_spacing", cyc - g_cyc, WIDTH + 2);
        req1 = 1'b0;
        wait_valids(2);

        run_single(0, 3, 9);
        @(negedge CLK);
        chk("hold_valid_low", {31'd0, out_valid}, 32'd0);
        chk("hold_out", {16'd0, out}, 32'd27);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        run_single(1, 111, 101);
        run_single(0, 255, 255);
        run_single(1, 0, 60);

        // Both held continuously from a fresh reset: grants alternate 0,1,0,1.
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        gnt_log.delete();
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd6;
        req1 = 1'b1; a1 = 8'd7; b1 = 8'd8;
        for (int j = 0; j < 4; j++) exp_q.push_back(mk(j[0], j[0] ? 7 : 5, j[0] ? 8 : 6));
        begin
            int base;
            base = nvalid;
            for (int j = 0; j < 200 && gnt_log.size() < 4; j++) @(negedge CLK);
            req0 = 1'b0; req1 = 1'b0;
            chk("alt_count", gnt_log.size(), 4);
            for (int j = 0; j < 4 && j < gnt_log.size(); j++)
                chk("alt_order", {31'd0, gnt_log[j]}, {31'd0, j[0]});
            wait_valids(base + 4);
        end

        // Reset four cycles into a job aborts it; a later retry completes.
        begin
            int base;
            base = nvalid;
            @(negedge CLK);
            req0 = 1'b1; a0 = 8'd1; b0 = 8'd60;
            wait_gnt(0, ok);
            req0 = 1'b0;
            repeat (4) @(negedge CLK);
            reset = 1'b1;
            req1 = 1'b1;
            @(negedge CLK);
            chk("abort_gnt0", {31'd0, gnt0}, 32'd0);
            chk("abort_gnt1", {31'd0, gnt1}, 32'd0);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_out", {16'd0, out}, 32'd0);
            chk("abort_out_id", {31'd0, out_id}, 32'd0);
            reset = 1'b0;
            req1 = 1'b0;
            repeat (15) @(negedge CLK);
            chk("abort_no_valid", nvalid, base);
            chk("abort_idle", {31'd0, busy}, 32'd0);
            run_single(0, 1, 60);
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
